fx_arb: RTL
===========

# fx_arb

Two-master arbiter for the fx register bus on `clk_sys`. It sits between the bus masters and the fx slave fabric (control, ov_inf and other `dev_id` decoders). Master 0 is the UART command path; master 1 is an on-chip sequencer, for example a future OV7670 register-init engine. The block serialises single-beat read/write transactions onto the shared `fx_wr`/`fx_rd` strobes and returns read data and a completion pulse to the winning master.

## Interface
- `RD_LAT`, default 2: cycles from the `fx_rd` pulse to valid `fx_q`. Legal range 1..15.
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_req`  in  1  master 0 transaction request; level, held until `m0_ack`.
- `m0_wr`  in  1  master 0 direction: 1 = write, 0 = read.
- `m0_addr`  in  22  master 0 address.
- `m0_wdata`  in  8  master 0 write data.
- `m0_ack`  out  1  master 0 completion pulse, one cycle.
- `m0_rdata`  out  8  master 0 read data; valid while `m0_ack`=1, held afterwards.
- `m1_req`, `m1_wr`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: identical set for master 1.
- `fx_wr`  out  1  bus write strobe, one cycle.
- `fx_waddr`  out  22  bus write address.
- `fx_data`  out  8  bus write data.
- `fx_rd`  out  1  bus read strobe, one cycle.
- `fx_raddr`  out  22  bus read address.
- `fx_q`  in  8  OR-combined slave read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - If any `mN_req`=1, choose a winner and latch its `wr`, `addr` and `wdata` into internal registers.
  - Record the winner as `last`, then go to ISSUE.
- **ISSUE** (one cycle)
  - Write: `fx_wr`=1, with `fx_waddr`/`fx_data` taken from the latched values. Next state is ACK.
  - Read: `fx_rd`=1, with `fx_raddr` taken from the latched value. Load the wait counter with `RD_LAT`. Next state is WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, capture `fx_q` into the winner's `rdata` register, then go to ACK.
- **ACK** (one cycle)
  - Winner's `ack`=1; go to IDLE.
- Masters sample `ack` on the clock edge and drop `req` at that same edge, so `req` is already low in the following IDLE cycle. A master that keeps `req` high is treated as issuing a new request.
- Bus address and data outputs hold their last driven values between transactions; strobes are 0 outside ISSUE.
- A write transaction leaves the winner's `rdata` unchanged. The losing master's `rdata` is never modified.
- Master inputs are only sampled in IDLE. Changes during a transaction are ignored.
- Reset:
  - All outputs go to 0 (strobes, addresses, data, acks, rdata), the FSM goes to IDLE and `last` = master 1.
  - A reset mid-transaction aborts it; no `ack` is ever issued for that transaction.

## Timing
- Request registered in IDLE at cycle T; strobe in cycle T+1.
- Write: `ack` at T+2. One write every 3 cycles per arbiter.
- Read: `fx_q` sampled in cycle T+1+RD_LAT; `ack` and `rdata` valid at T+2+RD_LAT. With RD_LAT=2 that is T+4.
- `mN_ack` and `fx_wr`/`fx_rd` are never high for more than one consecutive cycle.
- `m0_ack` and `m1_ack` are never high in the same cycle.
- `fx_wr` and `fx_rd` are never high in the same cycle.
- Simultaneous requests in IDLE are resolved per Configuration; the loser waits and is granted in the next IDLE.

## Configuration
- `FX_ARB_RR_EN` defined: round-robin. When both masters request, grant the master other than `last`. After reset, master 0 wins the first tie.
- `FX_ARB_RR_EN` undefined: fixed priority. Master 0 always wins ties, so master 1 can starve under continuous master 0 traffic. `last` is still tracked but not used.

## Test plan
- Reset with `m0_req`=1 held: all outputs 0 during reset. First cycle after release is IDLE; `fx_wr` at T+1, `m0_ack` at T+2.
- Master 0 write, addr 0x040012, data 0xA5: `fx_waddr`=0x040012 and `fx_data`=0xA5 with `fx_wr`=1 for exactly one cycle; `m0_ack` one cycle later; `m0_rdata` unchanged.
- Master 1 read, addr 0x080003, slave model drives `fx_q`=0x3C exactly 2 cycles after `fx_rd` (RD_LAT=2): `fx_raddr`=0x080003; `m1_ack` at T+4 with `m1_rdata`=0x3C; `m0_rdata` unchanged.
- Both masters request writes continuously for 6 transactions:
  - With `FX_ARB_RR_EN`: grants alternate m0, m1, m0, m1, m0, m1.
  - Without it: m0 ×6 and `m1_ack` never pulses.
- Assert `rst_n` during WAIT of a master 0 read: no `m0_ack`, `m0_rdata`=0 after reset; a subsequent master 0 read completes normally.
- Master 0 keeps `m0_req` high through `m0_ack`: a second transaction starts in the next IDLE. Strobes stay one-cycle and the two acks are separated by at least 2 cycles.

Source files
------------

// File: rtl/fx_arb.sv
// fx_arb -- two-master arbiter for the fx register bus (clk_sys domain).
//
// Serialises single-beat read/write transactions from two bus masters onto
// the shared fx_wr / fx_rd strobes. Read data and a one-cycle completion
// pulse go back to the master that won arbitration.
//
// Parameters:
//   RD_LAT      cycles from the fx_rd pulse to valid fx_q (1..15)
//
// Ports:
//   clk_sys     system clock, rising edge
//   rst_n       asynchronous active-low reset
//   mN_req      master N request level, held until mN_ack
//   mN_wr       master N direction (1 = write, 0 = read)
//   mN_addr     master N address (22 bits)
//   mN_wdata    master N write data (8 bits)
//   mN_ack      master N completion pulse (one cycle)
//   mN_rdata    master N read data, valid with mN_ack and held afterwards
//   fx_wr       bus write strobe (one cycle)
//   fx_waddr    bus write address, holds between transactions
//   fx_data     bus write data, holds between transactions
//   fx_rd       bus read strobe (one cycle)
//   fx_raddr    bus read address, holds between transactions
//   fx_q        OR-combined slave read data
//
// Build option:
//   FX_ARB_RR_EN  defined   -> round-robin on ties (winner alternates)
//                 undefined -> fixed priority, master 0 wins every tie
module fx_arb #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [21:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [21:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic        fx_wr,
  output logic [21:0] fx_waddr,
  output logic [7:0]  fx_data,
  output logic        fx_rd,
  output logic [21:0] fx_raddr,
  input  logic [7:0]  fx_q
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt;
  logic        cur_wr;    // direction of the transaction in flight
  logic        cur_sel;   // master that owns the transaction in flight
  logic        last;      // most recent winner
  logic        tie_sel;
  logic        grant_sel;
  logic        grant_wr;
  logic [21:0] grant_addr;
  logic [7:0]  grant_wdata;
  logic        load;
  logic        capture;

`ifdef FX_ARB_RR_EN
  // On a tie, hand the bus to whoever did not win last time.
  assign tie_sel = ~last;
`else
  // Fixed priority: master 0 always wins; last is tracked for debug only.
  assign tie_sel = 1'b0;
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    grant_sel = m1_req;
    if (m0_req && m1_req) grant_sel = tie_sel;
  end

  assign grant_wr    = grant_sel ? m1_wr    : m0_wr;
  assign grant_addr  = grant_sel ? m1_addr  : m0_addr;
  assign grant_wdata = grant_sel ? m1_wdata : m0_wdata;

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    capture = 1'b0;
    fx_wr   = 1'b0;
    fx_rd   = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        fx_wr   = cur_wr;
        fx_rd   = ~cur_wr;
        state_d = cur_wr ? ACK : WAIT;
      end
      WAIT: begin
        // Counter was loaded with RD_LAT, so this is the last wait cycle.
        if (cnt == 4'd1) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        m0_ack  = ~cur_sel;
        m1_ack  = cur_sel;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Winner's request is latched straight into the bus address/data
  // registers, which then hold until the next transaction of that kind.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cur_wr   <= 1'b0;
      cur_sel  <= 1'b0;
      last     <= 1'b1;
      cnt      <= 4'd0;
      fx_waddr <= '0;
      fx_data  <= '0;
      fx_raddr <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      if (load) begin
        cur_wr  <= grant_wr;
        cur_sel <= grant_sel;
        last    <= grant_sel;
        if (grant_wr) begin
          fx_waddr <= grant_addr;
          fx_data  <= grant_wdata;
        end else begin
          fx_raddr <= grant_addr;
        end
      end

      if (state == ISSUE && !cur_wr) cnt <= 4'(RD_LAT);
      else if (state == WAIT)        cnt <= cnt - 4'd1;

      if (capture) begin
        if (cur_sel) m1_rdata <= fx_q;
        else         m0_rdata <= fx_q;
      end
    end
  end

endmodule
